// File: rtl/fft_result_reader.sv
// Streams the N complex bins of a finished FFT out of one result BRAM bank,
// optionally undoing bit-reversed ordering, over a valid/ready interface.
module fft_result_reader #(
    parameter int N           = 64,
    parameter int DATA_WIDTH  = 8,
    parameter int BIT_REVERSE = 1,
    localparam int ADDR_WIDTH = $clog2(N),
    localparam int WORD_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bank_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en0,
    output logic                  ram_en1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [WORD_WIDTH-1:0] ram_dout0,
    input  logic [WORD_WIDTH-1:0] ram_dout1,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WORD_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic                  m_last
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic                  bank_q, bank_d;
    logic [ADDR_WIDTH:0]   rd_k_q, rd_k_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] infl_idx_q;
    logic [WORD_WIDTH-1:0] fifo_data_q [2];
    logic [ADDR_WIDTH-1:0] fifo_idx_q  [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q;
    logic                  done_q;

    logic                  issue, issue_bank, pop, push, credit_ok;
    logic [2:0]            occ;
    logic [ADDR_WIDTH-1:0] issue_k, issue_rev;

    assign m_valid = (count_q != 2'd0);
    assign m_data  = fifo_data_q[rd_ptr_q];
    assign m_index = fifo_idx_q[rd_ptr_q];
    assign m_last  = m_valid && (m_index == ADDR_WIDTH'(N - 1));
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;

    // A slot freed by this cycle's pop counts as credit, which keeps one bin per clock.
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = (occ < 3'd2);
    assign issue_k   = (state_q == S_READ) ? rd_k_q[ADDR_WIDTH-1:0] : '0;

    for (genvar gi = 0; gi < ADDR_WIDTH; gi++) begin : g_rev
        assign issue_rev[gi] = issue_k[ADDR_WIDTH-1-gi];
    end

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        rd_k_d     = rd_k_q;
        issue      = 1'b0;
        issue_bank = bank_q;
        case (state_q)
            S_IDLE: begin
                // Bin 0 is read in the start cycle itself so it is visible two cycles later.
                if (start) begin
                    issue      = 1'b1;
                    issue_bank = bank_sel;
                    bank_d     = bank_sel;
                    rd_k_d     = (ADDR_WIDTH+1)'(1);
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    rd_k_d = rd_k_q + 1'b1;
                    if (rd_k_q == (ADDR_WIDTH+1)'(N - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram_en0  = issue & ~issue_bank;
    assign ram_en1  = issue & issue_bank;
    assign ram_addr = !issue ? '0 : ((BIT_REVERSE != 0) ? issue_rev : issue_k);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bank_q     <= 1'b0;
            rd_k_q     <= '0;
            inflight_q <= 1'b0;
            infl_idx_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            done_q     <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            rd_k_q     <= rd_k_d;
            inflight_q <= issue;
            infl_idx_q <= issue_k;
            done_q     <= pop & m_last;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= bank_q ? ram_dout1 : ram_dout0;
                fifo_idx_q[wr_ptr_q]  <= infl_idx_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Runs a natural-order and a bit-reversed reader in lockstep against shared
// BRAM models; a queue scoreboard predicts every bin of every frame.
module tb_fft_result_reader;
    localparam int N  = 64;
    localparam int DW = 8;
    localparam int AW = $clog2(N);
    localparam int WW = 2 * DW;
    localparam int EW = 1 + AW + WW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic bank_sel = 1'b0;
    logic m_ready = 1'b0;
    logic cur_bank = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic          busy_w [2];
    logic          done_w [2];
    logic          en0_w [2];
    logic          en1_w [2];
    logic [AW-1:0] addr_w [2];
    logic [WW-1:0] dout0_w [2];
    logic [WW-1:0] dout1_w [2];
    logic          valid_w [2];
    logic [WW-1:0] data_w [2];
    logic [AW-1:0] index_w [2];
    logic          last_w [2];

    logic [WW-1:0] ram0 [N];
    logic [WW-1:0] ram1 [N];
    logic [EW-1:0] exp_q [2][$];

    int            en_cnt [2];
    int            done_cnt [2];
    int            wrong_en [2];
    int            outst [2];
    logic          stall_v [2];
    logic [WW-1:0] stall_data [2];
    logic [AW-1:0] stall_idx [2];
    logic          stall_last [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        fft_result_reader #(.N(N), .DATA_WIDTH(DW), .BIT_REVERSE(gi)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
            .busy(busy_w[gi]), .done(done_w[gi]),
            .ram_en0(en0_w[gi]), .ram_en1(en1_w[gi]), .ram_addr(addr_w[gi]),
            .ram_dout0(dout0_w[gi]), .ram_dout1(dout1_w[gi]),
            .m_valid(valid_w[gi]), .m_ready(m_ready), .m_data(data_w[gi]),
            .m_index(index_w[gi]), .m_last(last_w[gi])
        );
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (en0_w[d]) dout0_w[d] <= ram0[addr_w[d]];
            if (en1_w[d]) dout1_w[d] <= ram1[addr_w[d]];
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int b = 0; b < AW; b++)
            if ((k >> b) % 2 == 1) r += (1 << (AW - 1 - b));
        return r;
    endfunction

    // Monitor: pops the scoreboard on every accepted beat and polices the handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                exp_q[d].delete();
                outst[d] = 0;
                stall_v[d] = 1'b0;
            end else begin
                if (en0_w[d] || en1_w[d]) begin
                    en_cnt[d]++;
                    outst[d]++;
                end
                if ((en0_w[d] && cur_bank) || (en1_w[d] && !cur_bank)) wrong_en[d]++;
                if (stall_v[d]) begin
                    chk(valid_w[d] == 1'b1, $sformatf("d%0d_stall_valid", d), valid_w[d], 1);
                    chk(data_w[d] == stall_data[d], $sformatf("d%0d_stall_data", d), data_w[d], stall_data[d]);
                    chk(index_w[d] == stall_idx[d], $sformatf("d%0d_stall_index", d), index_w[d], stall_idx[d]);
                    chk(last_w[d] == stall_last[d], $sformatf("d%0d_stall_last", d), last_w[d], stall_last[d]);
                end
                if (valid_w[d] && m_ready) begin
                    outst[d]--;
                    if (exp_q[d].size() == 0) begin
                        chk(1'b0, $sformatf("d%0d_unexpected_beat", d), index_w[d], -1);
                    end else begin
                        logic [EW-1:0] e;
                        e = exp_q[d].pop_front();
                        chk(data_w[d] == e[WW-1:0], $sformatf("d%0d_data", d), data_w[d], e[WW-1:0]);
                        chk(index_w[d] == e[WW+:AW], $sformatf("d%0d_index", d), index_w[d], e[WW+:AW]);
                        chk(last_w[d] == e[EW-1], $sformatf("d%0d_last", d), last_w[d], e[EW-1]);
                    end
                end
                chk(outst[d] <= 2, $sformatf("d%0d_reads_ahead", d), outst[d], 2);
                stall_v[d]    = valid_w[d] & ~m_ready;
                stall_data[d] = data_w[d];
                stall_idx[d]  = index_w[d];
                stall_last[d] = last_w[d];
            end
            if (done_w[d]) done_cnt[d]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rams();
        for (int a = 0; a < N; a++) begin
            ram0[a] = WW'($urandom);
            ram1[a] = WW'($urandom);
        end
    endtask

    task automatic do_start(input logic bank, output int start_cyc);
        bank_sel = bank;
        cur_bank = bank;
        start = 1'b1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < N; k++) begin
                int a;
                logic [WW-1:0] w;
                a = (d == 1) ? bitrev(k) : k;
                w = bank ? ram1[a] : ram0[a];
                exp_q[d].push_back({(k == N - 1), AW'(k), w});
            end
        end
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input int mode, input int repulse, output int at);
        at = -1;
        for (int i = 0; i < 3000; i++) begin
            m_ready = (mode == 1) ? 1'($urandom % 2) : 1'b1;
            if (i == repulse) begin
                start = 1'b1;
                bank_sel = ~bank_sel;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done_w[0]) begin
                at = cyc;
                break;
            end
        end
        start = 1'b0;
        chk(at >= 0, "done_timeout", at, 0);
        for (int d = 0; d < 2; d++)
            chk(busy_w[d] == 1'b0, $sformatf("d%0d_busy_at_done", d), busy_w[d], 0);
    endtask

    task automatic frame_end(input int done0 [2], input int wrong0 [2], input string name);
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk(exp_q[d].size() == 0, $sformatf("d%0d_%s_bins_left", d, name), exp_q[d].size(), 0);
            chk(done_cnt[d] - done0[d] == 1, $sformatf("d%0d_%s_done_count", d, name), done_cnt[d] - done0[d], 1);
            chk(wrong_en[d] - wrong0[d] == 0, $sformatf("d%0d_%s_wrong_bank", d, name), wrong_en[d] - wrong0[d], 0);
        end
        $display("frame %s complete at cycle %0d checks=%0d", name, cyc, checks);
    endtask

    task automatic check_reset(input string name);
        for (int d = 0; d < 2; d++) begin
            chk(busy_w[d] == 1'b0 && done_w[d] == 1'b0, $sformatf("d%0d_%s_busy_done", d, name), {busy_w[d], done_w[d]}, 0);
            chk(en0_w[d] == 1'b0 && en1_w[d] == 1'b0, $sformatf("d%0d_%s_ram_en", d, name), {en0_w[d], en1_w[d]}, 0);
            chk(addr_w[d] == '0, $sformatf("d%0d_%s_ram_addr", d, name), addr_w[d], 0);
            chk(valid_w[d] == 1'b0 && last_w[d] == 1'b0, $sformatf("d%0d_%s_valid_last", d, name), {valid_w[d], last_w[d]}, 0);
            chk(data_w[d] == '0 && index_w[d] == '0, $sformatf("d%0d_%s_data_index", d, name), {data_w[d], index_w[d]}, 0);
        end
    endtask

    initial begin
        int sc, at;
        int done0 [2];
        int wrong0 [2];
        int en0 [2];

        for (int d = 0; d < 2; d++) begin
            en_cnt[d] = 0; done_cnt[d] = 0; wrong_en[d] = 0;
            outst[d] = 0; stall_v[d] = 1'b0;
        end
        fill_rams();
        tick(); tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        // Full-rate frame from bank 0 with identity contents.
        for (int a = 0; a < N; a++) ram0[a] = WW'(a);
        done0 = done_cnt; wrong0 = wrong_en;
        m_ready = 1'b1;
        do_start(1'b0, sc);
        run_frame(0, -1, at);
        chk(at - sc == N + 2, "start_to_done", at - sc, N + 2);
        frame_end(done0, wrong0, "fullrate");

        // Bank 1 with identity contents, random backpressure.
        for (int a = 0; a < N; a++) ram1[a] = WW'(a);
        done0 = done_cnt; wrong0 = wrong_en;
        do_start(1'b1, sc);
        run_frame(1, -1, at);
        frame_end(done0, wrong0, "bank1_random");

        // Randomised contents and backpressure over several frames.
        for (int f = 0; f < 4; f++) begin
            fill_rams();
            done0 = done_cnt; wrong0 = wrong_en;
            do_start(1'($urandom % 2), sc);
            run_frame(1, -1, at);
            frame_end(done0, wrong0, $sformatf("rand%0d", f));
        end

        // A second start mid-frame with the bank flipped must be ignored.
        fill_rams();
        done0 = done_cnt; wrong0 = wrong_en;
        do_start(1'b0, sc);
        run_frame(0, 10, at);
        frame_end(done0, wrong0, "restart_ignored");

        // Reset in the middle of a frame, then a clean frame.
        fill_rams();
        m_ready = 1'b1;
        do_start(1'b1, sc);
        for (int i = 0; i < 21; i++) tick();
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        done0 = done_cnt; wrong0 = wrong_en;
        do_start(1'b0, sc);
        run_frame(0, -1, at);
        chk(at - sc == N + 2, "post_reset_start_to_done", at - sc, N + 2);
        frame_end(done0, wrong0, "after_reset");

        // Long stall right after start: exactly two reads, bin 0 held.
        fill_rams();
        done0 = done_cnt; wrong0 = wrong_en; en0 = en_cnt;
        m_ready = 1'b0;
        do_start(1'b1, sc);
        for (int i = 0; i < 100; i++) tick();
        for (int d = 0; d < 2; d++) begin
            logic [EW-1:0] e;
            logic [WW-1:0] ed;
            e = exp_q[d][0];
            ed = e[WW-1:0];
            chk(en_cnt[d] - en0[d] == 2, $sformatf("d%0d_stall_reads", d), en_cnt[d] - en0[d], 2);
            chk(valid_w[d] == 1'b1, $sformatf("d%0d_stall_bin0_valid", d), valid_w[d], 1);
            chk(data_w[d] == ed, $sformatf("d%0d_stall_bin0_data", d), data_w[d], ed);
            chk(index_w[d] == '0, $sformatf("d%0d_stall_bin0_index", d), index_w[d], 0);
        end
        run_frame(0, -1, at);
        frame_end(done0, wrong0, "long_stall");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
